// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the FSM encoding plus the fetch NOP and watchdog defaults.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_D = 3'd1,
    WAIT_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } arb_state_e;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam int          DEF_TIMEOUT   = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the IF/MEM ports, the memory side and status.
// master drives requests and memory replies; slave is the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          stall;
  logic          timeout;
  logic          busy;

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    input  stall, timeout, busy
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    output stall, timeout, busy
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Transaction watchdog: counts WAIT cycles, flags the last allowed one.
// Clear has priority over enable.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM ports onto one single-port memory.
// Data wins; flushed fetches complete on the bus but are not acked.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          TIMEOUT   = DEF_TIMEOUT,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ack_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_valid_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_o,
  output logic          timeout_o,
  output logic          busy_o
);

  arb_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          discard_q, discard_d;
  logic          timeout_q, timeout_d;
  logic          wd_clr, wd_en, wd_expire;

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    discard_d  = discard_q;
    timeout_d  = timeout_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (dm_req_i) begin
          state_d = WAIT_D;
          we_d    = dm_we_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          wd_clr  = 1'b1;
        end else if (if_req_i && !if_flush_i) begin
          state_d = WAIT_I;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
          wd_clr  = 1'b1;
        end
      end
      WAIT_D: begin
        wd_en = 1'b1;
        if (mem_ready_i) begin
          state_d    = RESP_D;
          dm_rdata_d = we_q ? '0 : mem_rdata_i;
        end else if (wd_expire) begin
          state_d    = RESP_D;
          dm_rdata_d = '0;
          timeout_d  = 1'b1;
        end
      end
      WAIT_I: begin
        wd_en = 1'b1;
        if (if_flush_i)
          discard_d = 1'b1;
        if (mem_ready_i) begin
          state_d    = RESP_I;
          if_rdata_d = mem_rdata_i;
        end else if (wd_expire) begin
          state_d    = RESP_I;
          if_rdata_d = DW'(NOP_INSTR);
          timeout_d  = 1'b1;
        end
      end
      RESP_D: state_d = IDLE;
      RESP_I: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      discard_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      discard_q  <= discard_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_valid_o = (state_q == WAIT_D) || (state_q == WAIT_I);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ack_o    = (state_q == RESP_D);
  // A flush landing in the ack cycle itself must also kill the ack.
  assign if_ack_o    = (state_q == RESP_I) && !discard_q && !if_flush_i;
  assign timeout_o   = timeout_q;
  assign busy_o      = (state_q != IDLE);
  assign stall_o     = (dm_req_i & ~dm_ack_o)
                     | (if_req_i & ~if_ack_o & ~if_flush_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter.
// Per-cycle table plus timeout and async-reset sequences.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .if_req_i    (bus.if_req),
    .if_addr_i   (bus.if_addr),
    .if_flush_i  (bus.if_flush),
    .if_ack_o    (bus.if_ack),
    .if_rdata_o  (bus.if_rdata),
    .dm_req_i    (bus.dm_req),
    .dm_we_i     (bus.dm_we),
    .dm_addr_i   (bus.dm_addr),
    .dm_wdata_i  (bus.dm_wdata),
    .dm_ack_o    (bus.dm_ack),
    .dm_rdata_o  (bus.dm_rdata),
    .mem_valid_o (bus.mem_valid),
    .mem_we_o    (bus.mem_we),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (bus.mem_wdata),
    .mem_rdata_i (bus.mem_rdata),
    .mem_ready_i (bus.mem_ready),
    .stall_o     (bus.stall),
    .timeout_o   (bus.timeout),
    .busy_o      (bus.busy)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        ifl;
    logic        dmr;
    logic        dwe;
    logic [31:0] dma;
    logic [31:0] dmw;
    logic        rdy;
    logic [31:0] rdt;
    logic        vld;
    logic        we;
    logic [31:0] ma;
    logic [31:0] wd;
    logic        iack;
    logic [31:0] ird;
    logic        dack;
    logic [31:0] drd;
    logic        stl;
    logic        bsy;
  } vec_t;

  typedef logic [134:0] obs_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_req    = v.ifr;
    bus.if_addr   = v.ifa;
    bus.if_flush  = v.ifl;
    bus.dm_req    = v.dmr;
    bus.dm_we     = v.dwe;
    bus.dm_addr   = v.dma;
    bus.dm_wdata  = v.dmw;
    bus.mem_ready = v.rdy;
    bus.mem_rdata = v.rdt;
  endtask

  task automatic idle_in();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_flush  = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  function automatic obs_t raw_obs();
    return {bus.mem_valid, bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.if_ack, bus.if_rdata,
            bus.dm_ack, bus.dm_rdata, bus.stall,
            bus.busy, bus.timeout};
  endfunction

  task automatic add(input vec_t v);
    tv.push_back(v);
  endtask

  initial begin
    obs_t e;
    obs_t a;
    int   nv;
    logic got;
    logic [31:0] rd;
    logic to_at_ack;
    logic to_early;

    idle_in();
    // fetch only, ready on 2nd valid cycle
    add('{1,32'h10,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h10,0,0,0,0,0,0,0, 1,0,32'h10,0,0,0,0,0,1,1});
    add('{1,32'h10,0,0,0,0,0,1,32'h00500093,
          1,0,32'h10,0,0,0,0,0,1,1});
    add('{1,32'h10,0,0,0,0,0,0,0,
          0,0,0,0,1,32'h00500093,0,0,0,1});
    add('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    // simultaneous data read and fetch
    add('{1,32'h14,0,1,0,32'h100,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h14,0,1,0,32'h100,0,1,32'hCAFE0001,
          1,0,32'h100,0,0,0,0,0,1,1});
    add('{1,32'h14,0,1,0,32'h100,0,0,0,
          0,0,0,0,0,0,1,32'hCAFE0001,1,1});
    add('{1,32'h14,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h14,0,0,0,0,0,1,32'h00A00113,
          1,0,32'h14,0,0,0,0,0,1,1});
    add('{1,32'h14,0,0,0,0,0,0,0,
          0,0,0,0,1,32'h00A00113,0,0,0,1});
    add('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    // write, ready after three valid cycles
    add('{0,0,0,1,1,32'h200,32'hDEADBEEF,0,0,
          0,0,0,0,0,0,0,0,1,0});
    add('{0,0,0,1,1,32'h200,32'hDEADBEEF,0,0,
          1,1,32'h200,32'hDEADBEEF,0,0,0,0,1,1});
    add('{0,0,0,1,1,32'h200,32'hDEADBEEF,0,0,
          1,1,32'h200,32'hDEADBEEF,0,0,0,0,1,1});
    add('{0,0,0,1,1,32'h200,32'hDEADBEEF,1,32'h12345678,
          1,1,32'h200,32'hDEADBEEF,0,0,0,0,1,1});
    add('{0,0,0,1,1,32'h200,32'hDEADBEEF,0,0,
          0,0,0,0,0,0,1,0,0,1});
    add('{0,0,0,0,0,0,0,1,32'h55, 0,0,0,0,0,0,0,0,0,0});
    // flush one cycle before ready
    add('{1,32'h20,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h20,1,0,0,0,0,0,0, 1,0,32'h20,0,0,0,0,0,0,1});
    add('{1,32'h40,0,0,0,0,0,1,32'h11111111,
          1,0,32'h20,0,0,0,0,0,1,1});
    add('{1,32'h40,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1});
    add('{1,32'h40,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h40,0,0,0,0,0,1,32'h00000073,
          1,0,32'h40,0,0,0,0,0,1,1});
    add('{1,32'h40,0,0,0,0,0,0,0,
          0,0,0,0,1,32'h00000073,0,0,0,1});
    add('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    // flush in IDLE blocks the fetch grant
    add('{1,32'h50,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    add('{1,32'h50,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{1,32'h50,0,0,0,0,0,1,32'h2,
          1,0,32'h50,0,0,0,0,0,1,1});
    add('{1,32'h50,0,0,0,0,0,0,0, 0,0,0,0,1,32'h2,0,0,0,1});
    add('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    // flush during a data read is ignored
    add('{0,0,0,1,0,32'h300,0,0,0, 0,0,0,0,0,0,0,0,1,0});
    add('{0,0,1,1,0,32'h300,0,1,32'h77,
          1,0,32'h300,0,0,0,0,0,1,1});
    add('{0,0,0,1,0,32'h300,0,0,0, 0,0,0,0,0,0,1,32'h77,0,1});
    add('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});

    @(negedge clk);
    chk("reset_outputs", raw_obs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(negedge clk);
      e = {tv[i].vld, tv[i].we, tv[i].ma, tv[i].wd,
           tv[i].iack, tv[i].ird, tv[i].dack, tv[i].drd,
           tv[i].stl, tv[i].bsy, 1'b0};
      a = {bus.mem_valid,
           tv[i].vld ? bus.mem_we : 1'b0,
           tv[i].vld ? bus.mem_addr : 32'h0,
           (tv[i].vld && tv[i].we) ? bus.mem_wdata : 32'h0,
           bus.if_ack,
           tv[i].iack ? bus.if_rdata : 32'h0,
           bus.dm_ack,
           tv[i].dack ? bus.dm_rdata : 32'h0,
           bus.stall, bus.busy, bus.timeout};
      chk($sformatf("vec%0d", i), a, e);
      @(posedge clk); #1;
    end

    // timeout: memory never answers a fetch
    idle_in();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h60;
    nv = 0;
    got = 1'b0;
    rd = 32'h0;
    to_at_ack = 1'b0;
    to_early = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_valid) begin
        nv++;
        if (bus.timeout) to_early = 1'b1;
      end
      if (bus.if_ack) begin
        got = 1'b1;
        rd = bus.if_rdata;
        to_at_ack = bus.timeout;
      end
      @(posedge clk); #1;
    end
    chk("timeout_ack_seen", obs_t'(got), obs_t'(1));
    chk("timeout_valid_cycles", obs_t'(nv), obs_t'(255));
    chk("timeout_nop_data", obs_t'(rd), obs_t'(32'h13));
    chk("timeout_flag_at_ack", obs_t'(to_at_ack), obs_t'(1));
    chk("timeout_flag_early", obs_t'(to_early), obs_t'(0));
    bus.if_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout_sticky", obs_t'({bus.timeout, bus.busy}),
        obs_t'(2'b10));

    // async reset in the middle of a data read
    @(posedge clk); #1;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_wait", obs_t'({bus.mem_valid, bus.mem_addr}),
        obs_t'({1'b1, 32'h300}));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_clear",
        obs_t'({bus.mem_valid, bus.mem_we, bus.mem_addr,
                bus.mem_wdata, bus.if_ack, bus.if_rdata,
                bus.dm_ack, bus.dm_rdata, bus.busy,
                bus.timeout}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_regrant", obs_t'({bus.mem_valid, bus.mem_addr, bus.busy}),
        obs_t'({1'b1, 32'h300, 1'b1}));
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h99;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("rst_regrant_ack", obs_t'({bus.dm_ack, bus.dm_rdata}),
        obs_t'({1'b1, 32'h99}));
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write).
- Arbitrates between the two ports and sequences each transaction through a variable-latency ready handshake.
- Drops fetch responses killed by a branch flush.
- Generates the global pipeline stall; sits between the IF/MEM stages and the memory model.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max WAIT cycles before a transaction is force-completed
- NOP_INSTR, 32'h0000_0013, fetch data returned on timeout (addi x0,x0,0)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, level, held until if_ack_o
- if_addr_i  in  AW  fetch address, stable while if_req_i
- if_flush_i  in  1  branch taken; discard any in-flight fetch
- if_ack_o  out  1  one-cycle fetch completion
- if_rdata_o  out  DW  instruction, valid with if_ack_o
- dm_req_i  in  1  data request, level, held until dm_ack_o
- dm_we_i  in  1  1=write, 0=read
- dm_addr_i  in  AW  data address
- dm_wdata_i  in  DW  write data
- dm_ack_o  out  1  one-cycle data completion
- dm_rdata_o  out  DW  read data, valid with dm_ack_o
- mem_valid_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data, valid with mem_ready_i
- mem_ready_i  in  1  memory completion, one cycle
- stall_o  out  1  pipeline stall
- timeout_o  out  1  sticky timeout error
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i=0, async): state=IDLE; all outputs 0; rdata regs 0; discard flag 0; counter 0; timeout_o 0.
- States:
  - IDLE: arbitrate.
  - WAIT_D / WAIT_I: memory transaction in flight.
  - RESP_D / RESP_I: ack cycle.
- IDLE arbitration:
  - dm_req_i wins over if_req_i.
  - Fetch is granted only if dm_req_i=0 and if_flush_i=0.
  - On grant: register we/addr/wdata (we=0 for fetch), clear counter, go to WAIT_x.
- WAIT_x:
  - mem_valid_o=1; mem_* outputs stable.
  - Counter increments each cycle.
  - On mem_ready_i: capture mem_rdata_i, go to RESP_x.
  - On counter==TIMEOUT-1 with no ready: drop mem_valid_o, set timeout_o, load NOP_INSTR (fetch) or 0 (data), go to RESP_x.
- RESP_x:
  - Pulse x_ack_o with registered rdata, then return to IDLE.
  - Requests seen in RESP are not arbitrated until the following IDLE cycle.
- Latency: request in IDLE at cycle 0 -> mem_valid_o at cycle 1 -> ready at cycle N (N≥1) -> ack at cycle N+1 -> next grant at cycle N+2.
- Writes ack the same way; dm_rdata_o=0 on write acks.
- Flush:
  - if_flush_i in WAIT_I or RESP_I sets the discard flag.
  - The memory transaction still completes (no abort).
  - In RESP_I with discard set, if_ack_o is held at 0.
  - The discard flag clears on return to IDLE.
  - if_flush_i in IDLE/WAIT_D/RESP_D has no effect.
- stall_o = (dm_req_i & ~dm_ack_o) | (if_req_i & ~if_ack_o & ~if_flush_i). Combinational.
- Both requests arriving the same cycle: data serviced first; fetch is granted at the IDLE after RESP_D.
- mem_ready_i outside WAIT: ignored.
- timeout_o: cleared only by reset.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=0, WAIT_D, WAIT_I, RESP_D, RESP_I; 3-bit)
  - NOP_INSTR constant
  - TIMEOUT default
- One sub-module, mem_arb_wdog: counter with clear/enable inputs and an expire output at TIMEOUT-1.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Fetch only: if_req_i=1, addr 0x10, memory ready 2 cycles after mem_valid_o, rdata 0x00500093 -> mem_valid_o cycles 1-2, if_ack_o cycle 3 with 0x00500093, stall_o high cycles 0-2.
- Simultaneous: dm_req_i read 0x100 and if_req_i 0x14 both in cycle 0, ready latency 1 -> dm_ack_o cycle 2; fetch granted cycle 3, mem_addr_o=0x14 in cycle 4, if_ack_o cycle 5.
- Write: dm_we_i=1, addr 0x200, wdata 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF held until ready; dm_ack_o pulses one cycle with dm_rdata_o=0.
- Flush: fetch in WAIT_I, if_flush_i pulsed one cycle before mem_ready_i -> transaction completes, if_ack_o never asserts, next IDLE grants a new fetch address.
- Timeout: mem_ready_i tied 0, fetch issued -> mem_valid_o drops after 255 cycles, if_ack_o with 0x00000013, timeout_o=1 until reset.
- Reset mid-WAIT: rst_i low during WAIT_D -> all outputs 0 immediately (async); after release, state IDLE and a pending dm_req_i is re-granted.
